lv2_buf_sched: RTL and testbench

- Accept scheduler in front of the level-2 buffer in the top CDT.
- Grants or refuses each level-1 trigger request, issues the L1A pulse, and enforces a fixed dead time after every L1A.
- Tracks level-2 buffer slot occupancy; each lv2_done releases one slot.
- Produces lv2_buffer_full and live-run statistics: accepted, rejected on buffer full, and rejected on dead time.

---
 rtl/lv2_buf_sched.sv | 172 +++++++++++++++++
 tb/tb_lv2_buf_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lv2_buf_sched.sv
// Level-2 buffer accept scheduler: grants L1 requests, times the L1A pulse and dead time,
// tracks slot occupancy and keeps run statistics. Optional macro LIVE_GATE_EN gates requests by in_live.
module lv2_buf_sched #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned L1A_WIDTH = 2,
  parameter int unsigned DEAD_TIME = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_live,
  input  logic        lv1_req,
  input  logic        lv2_done,
  output logic        lv1a,
  output logic        lv2_buffer_full,
  output logic [7:0]  occupancy,
  output logic        lv2_underflow,
  output logic [31:0] lv1a_cnt,
  output logic [31:0] lv2_rej_cnt,
  output logic [31:0] dead_rej_cnt
);

  localparam int unsigned TMAX      = (L1A_WIDTH > DEAD_TIME) ? L1A_WIDTH : DEAD_TIME;
  localparam int unsigned TW        = (TMAX > 1) ? $clog2(TMAX + 1) : 1;
  localparam int unsigned ISSUE_LD  = L1A_WIDTH - 1;
  localparam int unsigned DEAD_LD   = (DEAD_TIME > 0) ? DEAD_TIME - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DEAD  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          lv1a_q, lv1a_d;
  logic          full_q, full_d;
  logic          uflow_q, uflow_d;
  logic          pre_live_q;
  logic [7:0]    occ_q, occ_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   frej_q, frej_d;
  logic [31:0]   drej_q, drej_d;

  logic req;
  logic grant;
  logic full_rej;
  logic dead_rej;
  logic live_rise;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

`ifdef LIVE_GATE_EN
  assign req = lv1_req & in_live;
`else
  assign req = lv1_req;
`endif

  assign live_rise = ~pre_live_q & in_live;
  // Dead-time rejection wins over buffer-full: any non-IDLE state refuses first.
  assign grant     = req && (state_q == IDLE) && !full_q;
  assign full_rej  = req && (state_q == IDLE) &&  full_q;
  assign dead_rej  = req && (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
          timer_d = TW'(ISSUE_LD);
        end
      end
      ISSUE: begin
        if (timer_q == '0) begin
          if (DEAD_TIME == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DEAD;
            timer_d = TW'(DEAD_LD);
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DEAD: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // lv1a is registered from the next state so it rises the cycle after the grant.
  always_comb begin
    lv1a_d = (state_d == ISSUE);
  end

  always_comb begin
    occ_d   = occ_q;
    uflow_d = uflow_q;
    if (grant && !lv2_done) begin
      occ_d = occ_q + 8'd1;
    end else if (!grant && lv2_done) begin
      if (occ_q != '0) begin
        occ_d = occ_q - 8'd1;
      end else begin
        uflow_d = 1'b1;
      end
    end
    full_d = (occ_d == 8'(DEPTH));
  end

  // Clear on the live rising edge first, then count this cycle's event on top.
  always_comb begin
    acc_d  = live_rise ? '0 : acc_q;
    frej_d = live_rise ? '0 : frej_q;
    drej_d = live_rise ? '0 : drej_q;
    if (grant)    acc_d  = sat_inc(acc_d);
    if (full_rej) frej_d = sat_inc(frej_d);
    if (dead_rej) drej_d = sat_inc(drej_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lv1a_q     <= 1'b0;
      full_q     <= 1'b0;
      uflow_q    <= 1'b0;
      occ_q      <= '0;
      pre_live_q <= 1'b0;
      acc_q      <= '0;
      frej_q     <= '0;
      drej_q     <= '0;
    end else begin
      lv1a_q     <= lv1a_d;
      full_q     <= full_d;
      uflow_q    <= uflow_d;
      occ_q      <= occ_d;
      pre_live_q <= in_live;
      acc_q      <= acc_d;
      frej_q     <= frej_d;
      drej_q     <= drej_d;
    end
  end

  assign lv1a            = lv1a_q;
  assign lv2_buffer_full = full_q;
  assign occupancy       = occ_q;
  assign lv2_underflow   = uflow_q;
  assign lv1a_cnt        = acc_q;
  assign lv2_rej_cnt     = frej_q;
  assign dead_rej_cnt    = drej_q;

endmodule

// File: tb/tb_lv2_buf_sched.sv
// Directed bench for lv2_buf_sched (DEPTH=8, L1A_WIDTH=2, DEAD_TIME=4) with hand-computed expectations.
module tb_lv2_buf_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_live;
  logic        lv1_req;
  logic        lv2_done;
  logic        lv1a;
  logic        lv2_buffer_full;
  logic [7:0]  occupancy;
  logic        lv2_underflow;
  logic [31:0] lv1a_cnt;
  logic [31:0] lv2_rej_cnt;
  logic [31:0] dead_rej_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  lv2_buf_sched #(
    .DEPTH     (8),
    .L1A_WIDTH (2),
    .DEAD_TIME (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_live         (in_live),
    .lv1_req         (lv1_req),
    .lv2_done        (lv2_done),
    .lv1a            (lv1a),
    .lv2_buffer_full (lv2_buffer_full),
    .occupancy       (occupancy),
    .lv2_underflow   (lv2_underflow),
    .lv1a_cnt        (lv1a_cnt),
    .lv2_rej_cnt     (lv2_rej_cnt),
    .dead_rej_cnt    (dead_rej_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic req, input logic done);
    lv1_req  = req;
    lv2_done = done;
    tick();
    lv1_req  = 1'b0;
    lv2_done = 1'b0;
  endtask

  task automatic check_cnts(input string tag, input int unsigned a, input int unsigned f,
                            input int unsigned d);
    check({tag, "_acc"},  lv1a_cnt,     a);
    check({tag, "_frej"}, lv2_rej_cnt,  f);
    check({tag, "_drej"}, dead_rej_cnt, d);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_live  = 1'b0;
    lv1_req  = 1'b0;
    lv2_done = 1'b0;
    idle(2);
    check("rst_lv1a", 32'(lv1a), 0);
    check("rst_full", 32'(lv2_buffer_full), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_uflow", 32'(lv2_underflow), 0);
    check_cnts("rst", 0, 0, 0);

    rst_n   = 1'b1;
    in_live = 1'b1;
    tick();

    // Single grant: lv1a high two cycles, then four dead cycles.
    pulse(1'b1, 1'b0);
    check("g1_lv1a0", 32'(lv1a), 1);
    check("g1_occ", 32'(occupancy), 1);
    check("g1_acc", lv1a_cnt, 1);
    tick();
    check("g1_lv1a1", 32'(lv1a), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("g1_dead_lv1a", 32'(lv1a), 0);
    end
    tick();

    // Grant, then requests 1, 3 and 6 cycles later are dead-rejected; 7 later is granted.
    pulse(1'b1, 1'b0);
    check("g2_occ", 32'(occupancy), 2);
    pulse(1'b1, 1'b0);
    tick();
    pulse(1'b1, 1'b0);
    check_cnts("dr2", 2, 0, 2);
    idle(2);
    pulse(1'b1, 1'b0);
    check("dr_edge_lv1a", 32'(lv1a), 0);
    check_cnts("dr3", 2, 0, 3);
    pulse(1'b1, 1'b0);
    check("g3_lv1a", 32'(lv1a), 1);
    check("g3_occ", 32'(occupancy), 3);
    check("g3_acc", lv1a_cnt, 3);
    idle(6);

    // Grant plus lv2_done in the same cycle keeps occupancy.
    pulse(1'b1, 1'b1);
    check("gd_occ", 32'(occupancy), 3);
    check("gd_lv1a", 32'(lv1a), 1);
    check("gd_acc", lv1a_cnt, 4);
    idle(6);

    // Fill to DEPTH.
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0);
      check("fill_occ", 32'(occupancy), 32'(4 + i));
      check("fill_full", 32'(lv2_buffer_full), (i == 4) ? 1 : 0);
      idle(6);
    end
    pulse(1'b1, 1'b0);
    check("f9_lv1a", 32'(lv1a), 0);
    check("f9_occ", 32'(occupancy), 8);
    check_cnts("f9", 9, 1, 3);

    // Done coincident with a request while full: refused, freed slot usable next cycle.
    pulse(1'b1, 1'b1);
    check("fd_lv1a", 32'(lv1a), 0);
    check("fd_occ", 32'(occupancy), 7);
    check("fd_full", 32'(lv2_buffer_full), 0);
    check("fd_frej", lv2_rej_cnt, 2);
    pulse(1'b1, 1'b0);
    check("fn_lv1a", 32'(lv1a), 1);
    check("fn_occ", 32'(occupancy), 8);
    check("fn_full", 32'(lv2_buffer_full), 1);
    pulse(1'b1, 1'b0);
    check_cnts("prio", 10, 2, 4);
    idle(5);

    // Drain, then underflow.
    for (int i = 0; i < 8; i++) begin
      pulse(1'b0, 1'b1);
      check("drain_occ", 32'(occupancy), 32'(7 - i));
      check("drain_full", 32'(lv2_buffer_full), 0);
    end
    check("pre_uflow", 32'(lv2_underflow), 0);
    pulse(1'b0, 1'b1);
    check("uflow_occ", 32'(occupancy), 0);
    check("uflow_set", 32'(lv2_underflow), 1);
    tick();
    check("uflow_sticky", 32'(lv2_underflow), 1);

    // Live falling edge does nothing; rising edge clears with same-cycle grant counted.
    in_live = 1'b0;
    tick();
    check_cnts("fall", 10, 2, 4);
`ifdef LIVE_GATE_EN
    pulse(1'b1, 1'b0);
    check("gate_lv1a", 32'(lv1a), 0);
    check("gate_occ", 32'(occupancy), 0);
    check_cnts("gate", 10, 2, 4);
`endif
    in_live = 1'b1;
    pulse(1'b1, 1'b0);
    check("rise_lv1a", 32'(lv1a), 1);
    check("rise_occ", 32'(occupancy), 1);
    check_cnts("rise", 1, 0, 0);

    // Asynchronous reset in the middle of an L1A.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_lv1a", 32'(lv1a), 0);
    check("arst_occ", 32'(occupancy), 0);
    check("arst_uflow", 32'(lv2_underflow), 0);
    check_cnts("arst", 0, 0, 0);
    tick();
    rst_n = 1'b1;
    pulse(1'b1, 1'b0);
    check("post_lv1a", 32'(lv1a), 1);
    check_cnts("post", 1, 0, 0);
    idle(7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
